// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe
// EX/MEM and MEM/WB pipeline registers of the pipelined CPU. Publishes the
// destination/enable/result fields used by the forwarding unit, drives the
// register-file write port (mem_wb_rd / mem_wb_regwrite / mem_wb_data),
// raises the load-use stall that forwarding cannot hide, and counts
// instructions retired from WB.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   mem_hold              freeze both stages and the counter
//   ex_flush              squash the instruction leaving EX
//   ex_*                  instruction fields presented by the EX stage
//   mem_read_data         data-memory read data for the load in MEM
//   id_rs, id_rt          source registers of the instruction in ID
//   ex_mem_*              EX/MEM register contents
//   mem_wb_*              MEM/WB register contents / regfile write port
//   load_use_stall        combinational stall request for IF/ID and ID/EX
//   retired_count         wrapping retired-instruction counter
module ex_mem_wb_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_hold,
   input  logic              ex_flush,
   input  logic              ex_valid,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memwrite,
   input  logic              ex_memread,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   output logic              ex_mem_valid,
   output logic [REG_W-1:0]  ex_mem_rd,
   output logic              ex_mem_regwrite,
   output logic              ex_mem_memwrite,
   output logic              ex_mem_memread,
   output logic [DATA_W-1:0] ex_mem_alu_result,
   output logic [DATA_W-1:0] ex_mem_store_data,
   output logic              mem_wb_valid,
   output logic [REG_W-1:0]  mem_wb_rd,
   output logic              mem_wb_regwrite,
   output logic [DATA_W-1:0] mem_wb_data,
   output logic              load_use_stall,
   output logic [CNT_W-1:0]  retired_count
);

   logic              w_advance;
   logic              w_ex_take;
   logic              w_rd_nonzero;
   logic [DATA_W-1:0] w_wb_data;

   logic              r_exm_valid;
   logic [REG_W-1:0]  r_exm_rd;
   logic              r_exm_regwrite;
   logic              r_exm_memwrite;
   logic              r_exm_memread;
   logic [DATA_W-1:0] r_exm_alu_result;
   logic [DATA_W-1:0] r_exm_store_data;

   logic              r_mwb_valid;
   logic [REG_W-1:0]  r_mwb_rd;
   logic              r_mwb_regwrite;
   logic [DATA_W-1:0] r_mwb_data;

   logic [CNT_W-1:0]  r_retired;

   // mem_hold freezes everything, so a pending flush waits for the advance
   assign w_advance    = ~mem_hold;
   assign w_ex_take    = ex_valid & ~ex_flush;
   assign w_rd_nonzero = (ex_rd != REG_W'(0));

   // Writeback value selection for the instruction currently in MEM
   assign w_wb_data = r_exm_memread ? mem_read_data : r_exm_alu_result;

   // EX/MEM register; bubbles are all-zero, r0 never advertises a write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exm_valid      <= 1'b0;
         r_exm_rd         <= '0;
         r_exm_regwrite   <= 1'b0;
         r_exm_memwrite   <= 1'b0;
         r_exm_memread    <= 1'b0;
         r_exm_alu_result <= '0;
         r_exm_store_data <= '0;
      end else if (w_advance) begin
         if (w_ex_take) begin
            r_exm_valid      <= 1'b1;
            r_exm_rd         <= ex_rd;
            r_exm_regwrite   <= ex_regwrite & w_rd_nonzero;
            r_exm_memwrite   <= ex_memwrite;
            r_exm_memread    <= ex_memread;
            r_exm_alu_result <= ex_alu_result;
            r_exm_store_data <= ex_store_data;
         end else begin
            r_exm_valid      <= 1'b0;
            r_exm_rd         <= '0;
            r_exm_regwrite   <= 1'b0;
            r_exm_memwrite   <= 1'b0;
            r_exm_memread    <= 1'b0;
            r_exm_alu_result <= '0;
            r_exm_store_data <= '0;
         end
      end
   end

   // MEM/WB register; a bubble in EX/MEM yields all-zero here too
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mwb_valid    <= 1'b0;
         r_mwb_rd       <= '0;
         r_mwb_regwrite <= 1'b0;
         r_mwb_data     <= '0;
      end else if (w_advance) begin
         r_mwb_valid    <= r_exm_valid;
         r_mwb_rd       <= r_exm_rd;
         r_mwb_regwrite <= r_exm_regwrite;
         r_mwb_data     <= w_wb_data;
      end
   end

   // Retire counter: counts the instruction leaving WB on each advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_advance && r_mwb_valid) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

   // Load in EX whose result is needed by ID next cycle cannot be forwarded
   assign load_use_stall = w_ex_take & ex_memread & w_rd_nonzero &
                           ((ex_rd == id_rs) | (ex_rd == id_rt));

   assign ex_mem_valid      = r_exm_valid;
   assign ex_mem_rd         = r_exm_rd;
   assign ex_mem_regwrite   = r_exm_regwrite;
   assign ex_mem_memwrite   = r_exm_memwrite;
   assign ex_mem_memread    = r_exm_memread;
   assign ex_mem_alu_result = r_exm_alu_result;
   assign ex_mem_store_data = r_exm_store_data;
   assign mem_wb_valid      = r_mwb_valid;
   assign mem_wb_rd         = r_mwb_rd;
   assign mem_wb_regwrite   = r_mwb_regwrite;
   assign mem_wb_data       = r_mwb_data;
   assign retired_count     = r_retired;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe with an instruction-level reference
// model and a per-cycle compare process, plus literal spot checks.
module tb_ex_mem_wb_pipe;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = 4;
   localparam int          CNT_MOD = 16;

   logic              clk;
   logic              rst_n;
   logic              mem_hold;
   logic              ex_flush;
   logic              ex_valid;
   logic [REG_W-1:0]  ex_rd;
   logic              ex_regwrite;
   logic              ex_memwrite;
   logic              ex_memread;
   logic [DATA_W-1:0] ex_alu_result;
   logic [DATA_W-1:0] ex_store_data;
   logic [DATA_W-1:0] mem_read_data;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic              ex_mem_valid;
   logic [REG_W-1:0]  ex_mem_rd;
   logic              ex_mem_regwrite;
   logic              ex_mem_memwrite;
   logic              ex_mem_memread;
   logic [DATA_W-1:0] ex_mem_alu_result;
   logic [DATA_W-1:0] ex_mem_store_data;
   logic              mem_wb_valid;
   logic [REG_W-1:0]  mem_wb_rd;
   logic              mem_wb_regwrite;
   logic [DATA_W-1:0] mem_wb_data;
   logic              load_use_stall;
   logic [CNT_W-1:0]  retired_count;

   int n_checks = 0;
   int n_errors = 0;

   ex_mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .mem_hold(mem_hold), .ex_flush(ex_flush),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memwrite(ex_memwrite), .ex_memread(ex_memread),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .mem_read_data(mem_read_data), .id_rs(id_rs), .id_rt(id_rt),
      .ex_mem_valid(ex_mem_valid), .ex_mem_rd(ex_mem_rd),
      .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memwrite(ex_mem_memwrite),
      .ex_mem_memread(ex_mem_memread), .ex_mem_alu_result(ex_mem_alu_result),
      .ex_mem_store_data(ex_mem_store_data), .mem_wb_valid(mem_wb_valid),
      .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
      .mem_wb_data(mem_wb_data), .load_use_stall(load_use_stall),
      .retired_count(retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one record per pipeline slot, empty slot = all zero
   typedef struct {
      bit        v;
      bit [4:0]  rd;
      bit        rw;
      bit        mw;
      bit        mr;
      bit [31:0] alu;
      bit [31:0] sd;
   } exm_t;

   typedef struct {
      bit        v;
      bit [4:0]  rd;
      bit        rw;
      bit [31:0] data;
   } mwb_t;

   exm_t m_exm;
   mwb_t m_mwb;
   int   m_cnt;

   function automatic exm_t empty_exm();
      exm_t e;
      e.v = 0; e.rd = 0; e.rw = 0; e.mw = 0; e.mr = 0; e.alu = 0; e.sd = 0;
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_exm = empty_exm();
         m_mwb.v = 0; m_mwb.rd = 0; m_mwb.rw = 0; m_mwb.data = 0;
         m_cnt = 0;
      end else if (!mem_hold) begin
         // oldest first: retire, then move MEM to WB, then EX to MEM
         if (m_mwb.v) m_cnt = (m_cnt + 1) % CNT_MOD;
         m_mwb.v    = m_exm.v;
         m_mwb.rd   = m_exm.rd;
         m_mwb.rw   = m_exm.rw;
         m_mwb.data = m_exm.mr ? mem_read_data : m_exm.alu;
         if (ex_valid && !ex_flush) begin
            m_exm.v   = 1;
            m_exm.rd  = ex_rd;
            m_exm.rw  = ex_regwrite && (ex_rd != 0);
            m_exm.mw  = ex_memwrite;
            m_exm.mr  = ex_memread;
            m_exm.alu = ex_alu_result;
            m_exm.sd  = ex_store_data;
         end else begin
            m_exm = empty_exm();
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected stall: a live load in EX whose nonzero destination is read in ID
   function automatic bit exp_stall();
      bit live_load;
      live_load = ex_valid && !ex_flush && ex_memread && (ex_rd != 0);
      return live_load && (ex_rd == id_rs || ex_rd == id_rt);
   endfunction

   always @(negedge clk) begin
      chk("cmp ex_mem_valid",    32'(ex_mem_valid),      32'(m_exm.v));
      chk("cmp ex_mem_rd",       32'(ex_mem_rd),         32'(m_exm.rd));
      chk("cmp ex_mem_regwrite", 32'(ex_mem_regwrite),   32'(m_exm.rw));
      chk("cmp ex_mem_memwrite", 32'(ex_mem_memwrite),   32'(m_exm.mw));
      chk("cmp ex_mem_memread",  32'(ex_mem_memread),    32'(m_exm.mr));
      chk("cmp ex_mem_alu",      ex_mem_alu_result,      m_exm.alu);
      chk("cmp ex_mem_sd",       ex_mem_store_data,      m_exm.sd);
      chk("cmp mem_wb_valid",    32'(mem_wb_valid),      32'(m_mwb.v));
      chk("cmp mem_wb_rd",       32'(mem_wb_rd),         32'(m_mwb.rd));
      chk("cmp mem_wb_regwrite", 32'(mem_wb_regwrite),   32'(m_mwb.rw));
      chk("cmp mem_wb_data",     mem_wb_data,            m_mwb.data);
      chk("cmp retired_count",   32'(retired_count),     32'(m_cnt));
      chk("cmp load_use_stall",  32'(load_use_stall),    32'(exp_stall()));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw,
                         input logic mw, input logic mr,
                         input logic [31:0] alu, input logic [31:0] sd);
      ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memwrite = mw;
      ex_memread = mr; ex_alu_result = alu; ex_store_data = sd;
   endtask

   int saved_cnt;

   initial begin
      rst_n = 1'b0; mem_hold = 1'b0; ex_flush = 1'b0;
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_read_data = 32'h0; id_rs = 5'd0; id_rt = 5'd0;

      repeat (2) tick();
      chk("reset ex_mem_valid", 32'(ex_mem_valid), 32'h0);
      chk("reset mem_wb_data",  mem_wb_data,       32'h0);
      chk("reset retired",      32'(retired_count), 32'h0);
      rst_n = 1'b1;

      // Mid-stream async reset
      set_ex(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0); tick();
      set_ex(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h22, 32'h0); tick();
      set_ex(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h33, 32'h0); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst ex_mem_valid", 32'(ex_mem_valid),     32'h0);
      chk("midrst ex_mem_alu",   ex_mem_alu_result,     32'h0);
      chk("midrst mem_wb_valid", 32'(mem_wb_valid),     32'h0);
      chk("midrst mem_wb_data",  mem_wb_data,           32'h0);
      chk("midrst retired",      32'(retired_count),    32'h0);
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #3 rst_n = 1'b1;

      // ALU chain
      set_ex(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0); tick();
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("alu ex_mem_rd",       32'(ex_mem_rd),        32'd5);
      chk("alu ex_mem_regwrite", 32'(ex_mem_regwrite),  32'd1);
      chk("alu ex_mem_alu",      ex_mem_alu_result,     32'h1234);
      tick();
      chk("alu mem_wb_rd",       32'(mem_wb_rd),        32'd5);
      chk("alu mem_wb_data",     mem_wb_data,           32'h1234);
      chk("alu mem_wb_regwrite", 32'(mem_wb_regwrite),  32'd1);
      chk("alu retired before",  32'(retired_count),    32'd0);
      tick();
      chk("alu retired after",   32'(retired_count),    32'd1);

      // Load path and load-use stall
      set_ex(1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
      id_rs = 5'd8; id_rt = 5'd0;
      #1 chk("stall rs match", 32'(load_use_stall), 32'd1);
      id_rs = 5'd9; id_rt = 5'd3;
      #1 chk("stall no match", 32'(load_use_stall), 32'd0);
      id_rs = 5'd1; id_rt = 5'd8;
      #1 chk("stall rt match", 32'(load_use_stall), 32'd1);
      tick();
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_read_data = 32'hDEADBEEF;
      chk("load ex_mem_memread", 32'(ex_mem_memread), 32'd1);
      tick();
      chk("load mem_wb_data", mem_wb_data, 32'hDEADBEEF);
      chk("load mem_wb_rd",   32'(mem_wb_rd), 32'd8);
      mem_read_data = 32'h0;
      set_ex(1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0);
      id_rs = 5'd0; id_rt = 5'd0;
      #1 chk("stall rd0", 32'(load_use_stall), 32'd0);
      ex_flush = 1'b1; id_rs = 5'd0;
      set_ex(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0); id_rt = 5'd6;
      #1 chk("stall flushed", 32'(load_use_stall), 32'd0);
      ex_flush = 1'b0;
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); tick();

      // r0 suppression and a store exposing rd
      saved_cnt = m_cnt;
      set_ex(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0); tick();
      set_ex(1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 32'h80, 32'hCAFE0001);
      chk("r0 ex_mem_regwrite", 32'(ex_mem_regwrite), 32'd0);
      chk("r0 ex_mem_valid",    32'(ex_mem_valid),    32'd1);
      tick();
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("r0 mem_wb_regwrite", 32'(mem_wb_regwrite), 32'd0);
      chk("r0 mem_wb_valid",    32'(mem_wb_valid),    32'd1);
      chk("st ex_mem_rd",       32'(ex_mem_rd),       32'd4);
      chk("st ex_mem_sd",       ex_mem_store_data,    32'hCAFE0001);
      chk("st ex_mem_memwrite", 32'(ex_mem_memwrite), 32'd1);
      tick();
      chk("r0 counted", 32'(retired_count), 32'((saved_cnt + 1) % CNT_MOD));
      tick(); tick();

      // Hold then flush
      set_ex(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0); tick();
      saved_cnt = m_cnt;
      mem_hold = 1'b1;
      set_ex(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h99, 32'h0);
      tick();
      chk("hold1 ex_mem_rd", 32'(ex_mem_rd), 32'd7);
      tick();
      chk("hold2 ex_mem_alu", ex_mem_alu_result, 32'h77);
      ex_flush = 1'b1;
      tick();
      chk("hold3 ex_mem_valid", 32'(ex_mem_valid), 32'd1);
      chk("hold3 ex_mem_rd",    32'(ex_mem_rd),    32'd7);
      chk("hold3 retired",      32'(retired_count), 32'(saved_cnt));
      mem_hold = 1'b0;
      tick();
      chk("flush ex_mem_valid", 32'(ex_mem_valid), 32'd0);
      chk("flush ex_mem_rd",    32'(ex_mem_rd),    32'd0);
      chk("flush mem_wb_rd",    32'(mem_wb_rd),    32'd7);
      chk("flush mem_wb_data",  mem_wb_data,       32'h77);
      ex_flush = 1'b0;
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); tick();

      // Counter wrap: 17 retirements on a 4-bit counter
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_ex(1'b1, 5'(i % 31 + 1), 1'b1, 1'b0, 1'b0, 32'(i * 3), 32'h0);
         tick();
      end
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); tick();
      chk("wrap retired", 32'(retired_count), 32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
Owns the EX/MEM and MEM/WB pipeline registers of the pipelined CPU. It is the producer side of the forwarding path: it publishes the rd, regwrite, memwrite and result fields that the forwarding unit compares against, and it drives the register-file write port. It also generates the load-use stall that forwarding cannot cover, and keeps a retired-instruction count.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register index width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_hold  in  1  data memory not ready; freeze both stages
ex_flush  in  1  squash the instruction leaving EX (branch/exception)
ex_valid  in  1  EX stage holds a real instruction
ex_rd  in  REG_W  destination register from EX
ex_regwrite  in  1  EX instruction writes the register file
ex_memwrite  in  1  EX instruction is a store
ex_memread  in  1  EX instruction is a load
ex_alu_result  in  DATA_W  ALU result / memory address
ex_store_data  in  DATA_W  forwarded rt value for stores
mem_read_data  in  DATA_W  data memory read data, valid in MEM stage
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
ex_mem_valid  out  1  EX/MEM holds a real instruction
ex_mem_rd  out  REG_W  EX/MEM destination
ex_mem_regwrite  out  1  EX/MEM register write enable
ex_mem_memwrite  out  1  EX/MEM store flag
ex_mem_memread  out  1  EX/MEM load flag
ex_mem_alu_result  out  DATA_W  EX/MEM result/address
ex_mem_store_data  out  DATA_W  EX/MEM store data
mem_wb_valid  out  1  MEM/WB holds a real instruction
mem_wb_rd  out  REG_W  MEM/WB destination, also the regfile write address
mem_wb_regwrite  out  1  MEM/WB write enable, also the regfile write enable
mem_wb_data  out  DATA_W  writeback value
load_use_stall  out  1  stall IF/ID and bubble ID/EX
retired_count  out  CNT_W  instructions retired from WB

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including retired_count. Outputs stay 0 until the first rising edge after deassertion.
- Advance = !mem_hold. When advance=0, all registers and the counter hold. mem_hold overrides ex_flush; upstream keeps ex_flush asserted until the stage actually advances.
- EX/MEM capture on advance:
  - Bubble if ex_flush=1 or ex_valid=0: valid, regwrite, memwrite and memread are 0; rd, alu_result and store_data are 0.
  - Otherwise capture all EX fields.
  - ex_mem_regwrite is forced to 0 when ex_rd==0, so r0 never matches in the forwarding compare.
- MEM/WB capture on advance: valid, rd and regwrite copy from EX/MEM. mem_wb_data = ex_mem_memread ? mem_read_data : ex_mem_alu_result. Bubbles propagate as all-zero.
- Latency: an EX input is visible on ex_mem_* 1 cycle later and on mem_wb_* 2 cycles later, plus one cycle for each cycle mem_hold is asserted.
- retired_count increments by 1 on each advancing edge where mem_wb_valid=1. It wraps modulo 2^CNT_W with no saturation.
- load_use_stall (combinational) = ex_valid & !ex_flush & ex_memread & (ex_rd!=0) & ((ex_rd==id_rs)|(ex_rd==id_rt)). It is independent of mem_hold.
- Simultaneous MEM/WB write and EX/MEM write to the same rd: both registers are updated normally. Priority between them belongs to the forwarding unit, not this block.
- Store data passes through unmodified. A store with regwrite=0 still exposes ex_mem_rd for store-data forwarding.

Test Plan:
- Reset mid-stream: drive 3 valid ALU ops, pull rst_n low between edges -> all outputs read 0 immediately; retired_count=0.
- ALU chain: EX op rd=5, result 0x1234, regwrite=1 -> next cycle ex_mem_rd=5, ex_mem_regwrite=1, ex_mem_alu_result=0x1234; the cycle after, mem_wb_rd=5, mem_wb_data=0x1234, mem_wb_regwrite=1; retired_count goes 0->1 one edge later.
- Load path: EX load rd=8, addr 0x40, mem_read_data=0xDEADBEEF in MEM -> mem_wb_data=0xDEADBEEF. With id_rs=8 while the load is in EX -> load_use_stall=1; with id_rs=9, id_rt=3 -> 0; with a load to rd=0 and id_rs=0 -> 0.
- r0 suppression: EX op with rd=0, regwrite=1 -> ex_mem_regwrite=0, mem_wb_regwrite=0, mem_wb_valid=1, count still increments.
- Hold/flush: assert mem_hold for 3 cycles with a valid op in EX/MEM -> all outputs frozen and the counter is unchanged. Assert ex_flush together with mem_hold -> nothing squashed. Release mem_hold with ex_flush=1 -> EX/MEM becomes a bubble.
- Counter wrap (CNT_W=4): retire 17 valid ops back-to-back -> retired_count reads 1.
